// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART frame defaults and receiver/transmitter state encodings
package uart_rx_pkg;
  localparam int UART_OS = 16;
  localparam int UART_DBIT = 8;
  localparam int UART_SB_TICK = 16;
  localparam logic [1:0] UART_IDLE = 2'b00;
  localparam logic [1:0] UART_START = 2'b01;
  localparam logic [1:0] UART_DATA = 2'b10;
  localparam logic [1:0] UART_STOP = 2'b11;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input with selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], i_d};
  assign o_q = sync_q[1];
  always_ff @(posedge i_clk) begin
    if (!i_reset) sync_q <= {2{RST_VAL}};
    else sync_q <= sync_d;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, LSB first, no parity, with frame error flag
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK,
  parameter int OS = UART_OS
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_frame_error
);
  localparam int SW = $clog2(max2(OS, SB_TICK)) + 1;
  localparam int NW = $clog2(DBIT);
  logic            rx_s;
  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    b_d = b_q;
    data_d = data_q;
    fe_d = fe_q;
    done_d = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!rx_s) begin
          state_d = UART_START;
          s_d = '0;
        end
      end
      UART_START: begin
        if (i_s_tick) begin
          if (s_q == SW'(OS / 2 - 1)) begin
            state_d = rx_s ? UART_IDLE : UART_DATA;
            s_d = '0;
            n_d = '0;
          end else s_d = s_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (i_s_tick) begin
          if (s_q == SW'(OS - 1)) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            state_d = (n_q == NW'(DBIT - 1)) ? UART_STOP : UART_DATA;
            n_d = (n_q == NW'(DBIT - 1)) ? n_q : n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      end
      default: begin
        if (i_s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            data_d = b_q;
            fe_d = ~rx_s;
            done_d = 1'b1;
            state_d = UART_IDLE;
            s_d = '0;
          end else s_d = s_q + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= UART_IDLE;
      s_q <= '0;
      n_q <= '0;
      b_q <= '0;
      data_q <= '0;
      fe_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      b_q <= b_d;
      data_q <= data_d;
      fe_q <= fe_d;
      done_q <= done_d;
    end
  end
  assign o_data = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_error = fe_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx covering framing, glitch, errors, reset and tick pacing
module tb_uart_rx;
  typedef struct {
    logic [7:0] data;
    logic       fe;
    int         lat;
  } exp_t;
  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done_tick;
  logic       o_frame_error;
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cnt = 0;
  int         per = 1;
  int         tcnt = 0;
  logic       freeze = 1'b0;
  logic       prev_done = 1'b0;
  exp_t       q[$];
  uart_rx dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_s_tick      (s_tick),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_rx_done_tick(o_rx_done_tick),
    .o_frame_error (o_frame_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (freeze) s_tick = 1'b0;
    else begin
      tcnt = (tcnt >= per - 1) ? 0 : tcnt + 1;
      s_tick = (tcnt == 0);
    end
  end
  always @(negedge clk) begin
    if (o_rx_done_tick) begin
      exp_t e;
      done_cnt++;
      tests++;
      if (prev_done) begin
        failed++;
        $display("FAIL done_single: done high %0d consecutive cycles, required 1", 2);
      end
      tests++;
      if (q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_done: got data %h, required no pulse", o_data);
      end else begin
        e = q.pop_front();
        tests += 2;
        if (o_data !== e.data) begin
          failed++;
          $display("FAIL rx_data: got %h, required %h", o_data, e.data);
        end
        if (o_frame_error !== e.fe) begin
          failed++;
          $display("FAIL rx_frame_error: got %b, required %b", o_frame_error, e.fe);
        end
        if (e.lat >= 0) begin
          tests++;
          if (cyc - start_cyc !== e.lat) begin
            failed++;
            $display("FAIL rx_latency: got %0d cycles, required %0d", cyc - start_cyc, e.lat);
          end
        end
      end
    end
    prev_done = o_rx_done_tick;
  end
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!s_tick);
    end
    #2;
  endtask
  task automatic wait_idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [7:0] d, input logic fe, input int lat);
    exp_t e;
    e.data = d;
    e.fe = fe;
    e.lat = lat;
    q.push_back(e);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_at, input int frz_at);
    logic [9:0] f;
    int d0;
    logic [7:0] hold;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = f[i];
      if (i == 0) start_cyc = cyc;
      if (i == rst_at) begin
        wait_ticks(8);
        i_reset = 1'b0;
        @(posedge clk);
        #2;
        i_reset = 1'b1;
        tests += 2;
        if (o_data !== 8'h00) begin
          failed++;
          $display("FAIL reset_mid_data: got %h, required %h", o_data, 8'h00);
        end
        if (o_rx_done_tick !== 1'b0) begin
          failed++;
          $display("FAIL reset_mid_done: got %b, required %b", o_rx_done_tick, 1'b0);
        end
        wait_ticks(8);
      end else if (i == frz_at) begin
        wait_ticks(8);
        freeze = 1'b1;
        d0 = done_cnt;
        hold = o_data;
        repeat (1000) @(posedge clk);
        #2;
        tests += 2;
        if (done_cnt !== d0) begin
          failed++;
          $display("FAIL freeze_done: got %0d pulses, required %0d", done_cnt, d0);
        end
        if (o_data !== hold) begin
          failed++;
          $display("FAIL freeze_data: got %h, required %h", o_data, hold);
        end
        freeze = 1'b0;
        wait_ticks(8);
      end else wait_ticks(16);
    end
    i_rx = 1'b1;
  endtask
  task automatic check_drained(input string name);
    tests++;
    if (q.size() !== 0) begin
      failed++;
      $display("FAIL %s_drained: %0d frames outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic test_reset;
    tests += 3;
    if (o_data !== 8'h00) begin
      failed++;
      $display("FAIL reset_data: got %h, required %h", o_data, 8'h00);
    end
    if (o_rx_done_tick !== 1'b0) begin
      failed++;
      $display("FAIL reset_done: got %b, required %b", o_rx_done_tick, 1'b0);
    end
    if (o_frame_error !== 1'b0) begin
      failed++;
      $display("FAIL reset_fe: got %b, required %b", o_frame_error, 1'b0);
    end
  endtask
  task automatic test_basic;
    int d0;
    d0 = done_cnt;
    push(8'hA5, 1'b0, 155);
    send_frame(8'hA5, 1'b1, -1, -1);
    wait_idle(40);
    check_drained("basic");
    tests++;
    if (done_cnt - d0 !== 1) begin
      failed++;
      $display("FAIL basic_pulses: got %0d, required %0d", done_cnt - d0, 1);
    end
  endtask
  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    i_rx = 1'b0;
    wait_ticks(4);
    i_rx = 1'b1;
    wait_ticks(40);
    tests += 2;
    if (done_cnt !== d0) begin
      failed++;
      $display("FAIL glitch_done: got %0d pulses, required %0d", done_cnt, d0);
    end
    if (o_data !== 8'hA5) begin
      failed++;
      $display("FAIL glitch_data: got %h, required %h", o_data, 8'hA5);
    end
  endtask
  task automatic test_frame_error;
    push(8'h3C, 1'b1, -1);
    send_frame(8'h3C, 1'b0, -1, -1);
    wait_idle(64);
    check_drained("ferr");
    tests++;
    if (o_frame_error !== 1'b1) begin
      failed++;
      $display("FAIL ferr_held: got %b, required %b", o_frame_error, 1'b1);
    end
    push(8'h81, 1'b0, -1);
    send_frame(8'h81, 1'b1, -1, -1);
    wait_idle(40);
    check_drained("clean");
    tests += 2;
    if (o_frame_error !== 1'b0) begin
      failed++;
      $display("FAIL clean_fe: got %b, required %b", o_frame_error, 1'b0);
    end
    if (o_data !== 8'h81) begin
      failed++;
      $display("FAIL clean_data: got %h, required %h", o_data, 8'h81);
    end
  endtask
  task automatic test_back_to_back;
    int d0;
    d0 = done_cnt;
    push(8'h00, 1'b0, -1);
    push(8'hFF, 1'b0, -1);
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    wait_idle(40);
    check_drained("b2b");
    tests++;
    if (done_cnt - d0 !== 2) begin
      failed++;
      $display("FAIL b2b_pulses: got %0d, required %0d", done_cnt - d0, 2);
    end
  endtask
  task automatic test_reset_mid_frame;
    int d0;
    d0 = done_cnt;
    send_frame(8'hF0, 1'b1, 5, -1);
    wait_idle(40);
    tests++;
    if (done_cnt !== d0) begin
      failed++;
      $display("FAIL abort_done: got %0d pulses, required %0d", done_cnt, d0);
    end
    push(8'h5A, 1'b0, -1);
    send_frame(8'h5A, 1'b1, -1, -1);
    wait_idle(40);
    check_drained("after_reset");
    tests++;
    if (o_data !== 8'h5A) begin
      failed++;
      $display("FAIL after_reset_data: got %h, required %h", o_data, 8'h5A);
    end
  endtask
  task automatic test_slow_tick;
    per = 16;
    wait_idle(40);
    push(8'hC3, 1'b0, -1);
    send_frame(8'hC3, 1'b1, -1, 4);
    wait_idle(16 * 40);
    check_drained("slow");
    tests++;
    if (o_data !== 8'hC3) begin
      failed++;
      $display("FAIL slow_data: got %h, required %h", o_data, 8'hC3);
    end
  endtask
  initial begin
    wait_idle(3);
    test_reset;
    i_reset = 1'b1;
    wait_idle(4);
    test_basic;
    test_glitch;
    test_frame_error;
    test_back_to_back;
    test_reset_mid_frame;
    test_slow_tick;
    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
